// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, FSM states and byte helper for the S-box scheduler
package aes_pkg;

   localparam int STATE_BYTES = 16;
   localparam int WORD_BYTES  = 4;
   localparam int CNT_W       = $clog2(STATE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN_ST,
      S_RUN_WD,
      S_DONE_ST,
      S_DONE_WD
   } sched_state_t;

   function automatic logic [7:0] slice_byte(input logic [8*STATE_BYTES-1:0] v,
                                             input logic [CNT_W-1:0]         idx);
      return v[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/sbox_scheduler_if.sv
// rtl/sbox_scheduler_if.sv - request/response channels between requesters and the S-box scheduler
interface sbox_scheduler_if;
   import aes_pkg::*;

   logic                     st_in_valid;
   logic                     st_in_ready;
   logic [8*STATE_BYTES-1:0] st_in_data;
   logic                     st_out_valid;
   logic                     st_out_ready;
   logic [8*STATE_BYTES-1:0] st_out_data;
   logic                     wd_in_valid;
   logic                     wd_in_ready;
   logic [8*WORD_BYTES-1:0]  wd_in_data;
   logic                     wd_out_valid;
   logic                     wd_out_ready;
   logic [8*WORD_BYTES-1:0]  wd_out_data;
   logic                     busy;

   modport master (
      output st_in_valid, st_in_data, st_out_ready,
      output wd_in_valid, wd_in_data, wd_out_ready,
      input  st_in_ready, st_out_valid, st_out_data,
      input  wd_in_ready, wd_out_valid, wd_out_data, busy
   );

   modport slave (
      input  st_in_valid, st_in_data, st_out_ready,
      input  wd_in_valid, wd_in_data, wd_out_ready,
      output st_in_ready, st_out_valid, st_out_data,
      output wd_in_ready, wd_out_valid, wd_out_data, busy
   );

endinterface

// File: rtl/SBoxLookup.sv
// rtl/SBoxLookup.sv - combinational AES forward S-box, one byte in, one byte out
module SBoxLookup (
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_data = SBOX[i_data];

endmodule

// File: rtl/sbox_scheduler.sv
// rtl/sbox_scheduler.sv - arbitrates SubBytes and SubWord jobs onto one shared S-box, one byte per cycle
module sbox_scheduler
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   sbox_scheduler_if.slave  bus
);

   sched_state_t             r_state;
   sched_state_t             w_next;
   logic [CNT_W-1:0]         r_cnt;
   logic [8*STATE_BYTES-1:0] r_work;
   logic                     r_prio_wd;
   logic                     w_grant_st;
   logic                     w_grant_wd;
   logic                     w_last;
   logic [7:0]               w_sbox_in;
   logic [7:0]               w_sbox_out;

   SBoxLookup u_sbox (
      .i_data (w_sbox_in),
      .o_data (w_sbox_out)
   );

   assign w_sbox_in = slice_byte(r_work, r_cnt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_grant_st = 1'b0;
      w_grant_wd = 1'b0;
      w_last     = 1'b0;
      case (r_state)
         S_IDLE: begin
            // r_prio_wd breaks ties only; a lone requester always wins
            w_grant_st = bus.st_in_valid & (~bus.wd_in_valid | ~r_prio_wd);
            w_grant_wd = bus.wd_in_valid & (~bus.st_in_valid |  r_prio_wd);
            if (w_grant_st)      w_next = S_RUN_ST;
            else if (w_grant_wd) w_next = S_RUN_WD;
         end
         S_RUN_ST: begin
            w_last = (r_cnt == CNT_W'(STATE_BYTES - 1));
            if (w_last) w_next = S_DONE_ST;
         end
         S_RUN_WD: begin
            w_last = (r_cnt == CNT_W'(WORD_BYTES - 1));
            if (w_last) w_next = S_DONE_WD;
         end
         S_DONE_ST: if (bus.st_out_ready) w_next = S_IDLE;
         S_DONE_WD: if (bus.wd_out_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_work    <= '0;
         r_prio_wd <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_st) begin
                  r_work    <= bus.st_in_data;
                  r_cnt     <= '0;
                  r_prio_wd <= 1'b1;
               end else if (w_grant_wd) begin
                  r_work    <= {{(8*(STATE_BYTES-WORD_BYTES)){1'b0}}, bus.wd_in_data};
                  r_cnt     <= '0;
                  r_prio_wd <= 1'b0;
               end
            end
            S_RUN_ST, S_RUN_WD: begin
               r_work[{r_cnt, 3'b000} +: 8] <= w_sbox_out;
               r_cnt                        <= w_last ? '0 : r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.st_in_ready  = w_grant_st;
   assign bus.wd_in_ready  = w_grant_wd;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.st_out_valid = (r_state == S_DONE_ST);
   assign bus.wd_out_valid = (r_state == S_DONE_WD);
   assign bus.st_out_data  = bus.st_out_valid ? r_work : '0;
   assign bus.wd_out_data  = bus.wd_out_valid ? r_work[8*WORD_BYTES-1:0] : '0;

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb/tb_sbox_scheduler.sv - self-checking bench for sbox_scheduler against a GF(2^8) reference model
module tb_sbox_scheduler;
   import aes_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sbox_scheduler_if u_if ();

   sbox_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   int         n_vec  = 0;
   int         n_fail = 0;
   logic [7:0] ref_sbox [256];
   bit         fav_wd;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
      return (v << k) | (v >> (8 - k));
   endfunction

   task automatic build_ref();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_sub(input logic [127:0] d, input int n);
      logic [127:0] r;
      r = d;
      for (int i = 0; i < n; i++) r[8*i +: 8] = ref_sbox[d[8*i +: 8]];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      u_if.st_in_valid  = 1'b0;
      u_if.st_in_data   = '0;
      u_if.st_out_ready = 1'b0;
      u_if.wd_in_valid  = 1'b0;
      u_if.wd_in_data   = '0;
      u_if.wd_out_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " busy"},         u_if.busy,         '0);
      chk({tag, " st_in_ready"},  u_if.st_in_ready,  '0);
      chk({tag, " wd_in_ready"},  u_if.wd_in_ready,  '0);
      chk({tag, " st_out_valid"}, u_if.st_out_valid, '0);
      chk({tag, " wd_out_valid"}, u_if.wd_out_valid, '0);
      chk({tag, " st_out_data"},  u_if.st_out_data,  '0);
      chk({tag, " wd_out_data"},  u_if.wd_out_data,  '0);
   endtask

   // Offers one or both jobs, follows the granted one to its output handshake.
   task automatic run_job(input bit st_v, input bit wd_v, input logic [127:0] sd,
                          input logic [31:0] wdd, input int hold);
      bit           exp_st;
      int           n, cyc;
      logic [127:0] exp_d, obs_d;
      logic         out_v;
      exp_st = st_v && (!wd_v || !fav_wd);
      u_if.st_in_valid = st_v; u_if.st_in_data = sd;
      u_if.wd_in_valid = wd_v; u_if.wd_in_data = wdd;
      #1;
      chk("grant st_in_ready", u_if.st_in_ready, exp_st);
      chk("grant wd_in_ready", u_if.wd_in_ready, !exp_st);
      @(posedge clk); #1;
      fav_wd = exp_st;
      if (exp_st) u_if.st_in_valid = 1'b0;
      else        u_if.wd_in_valid = 1'b0;
      n     = exp_st ? STATE_BYTES : WORD_BYTES;
      exp_d = exp_st ? ref_sub(sd, STATE_BYTES) : ref_sub({96'b0, wdd}, WORD_BYTES);
      cyc   = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         out_v = exp_st ? u_if.st_out_valid : u_if.wd_out_valid;
      end while (!out_v && cyc < 64);
      chk("latency", cyc, n);
      chk("busy in DONE", u_if.busy, 1'b1);
      chk("other out_valid", exp_st ? u_if.wd_out_valid : u_if.st_out_valid, 1'b0);
      obs_d = exp_st ? u_if.st_out_data : {96'b0, u_if.wd_out_data};
      chk(exp_st ? "st_out_data" : "wd_out_data", obs_d, exp_d);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         obs_d = exp_st ? u_if.st_out_data : {96'b0, u_if.wd_out_data};
         chk("held data", obs_d, exp_d);
         chk("held valid", exp_st ? u_if.st_out_valid : u_if.wd_out_valid, 1'b1);
         chk("stalled in_ready", {u_if.st_in_ready, u_if.wd_in_ready}, 2'b00);
      end
      if (exp_st) u_if.st_out_ready = 1'b1;
      else        u_if.wd_out_ready = 1'b1;
      @(posedge clk); #1;
      u_if.st_out_ready = 1'b0;
      u_if.wd_out_ready = 1'b0;
      chk("busy after handshake", u_if.busy, 1'b0);
      chk("out_valid after handshake", {u_if.st_out_valid, u_if.wd_out_valid}, 2'b00);
      u_if.st_in_valid = 1'b0;
      u_if.wd_in_valid = 1'b0;
   endtask

   initial begin
      logic [127:0] sd;
      int           r;
      idle_inputs();
      build_ref();
      fav_wd = 1'b0;
      #2 reset = 1'b1;
      #1 check_all_zero("reset");
      u_if.st_in_valid = 1'b1;
      #1 chk("reset st_in_ready with valid", u_if.st_in_ready, 1'b1);
      u_if.st_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      run_job(1'b1, 1'b0, 128'h0, 32'h0, 0);
      run_job(1'b0, 1'b1, 128'h0, 32'h00010203, 0);

      run_job(1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff, 32'hdeadbeef, 10);
      run_job(1'b1, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100, 32'hcafef00d, 0);
      run_job(1'b1, 1'b1, 128'h0123456789abcdeffedcba9876543210, 32'h11223344, 0);
      run_job(1'b1, 1'b1, 128'hffffffffffffffffffffffffffffffff, 32'h55aa55aa, 3);

      sd = '0; sd[7:0] = 8'h53; sd[127:120] = 8'hff;
      run_job(1'b1, 1'b0, sd, 32'h0, 0);

      u_if.st_in_valid = 1'b1; u_if.st_in_data = 128'h000102030405060708090a0b0c0d0e0f;
      @(posedge clk); #1;
      u_if.st_in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      #1 check_all_zero("mid-job reset");
      @(posedge clk); #1 reset = 1'b0;
      fav_wd = 1'b0;
      run_job(1'b0, 1'b1, 128'h0, 32'hffffffff, 0);

      for (int it = 0; it < 16; it++) begin
         r  = $urandom_range(1, 3);
         sd = {$urandom, $urandom, $urandom, $urandom};
         run_job(r[0], r[1], sd, $urandom, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
